// File: rtl/rcp_iter.sv
// Multi-cycle Newton-Raphson reciprocal: normalise, linear seed, ITERS refinement steps.
// Optional exact-floor correction stage enabled by defining RCP_ITER_ROUND_EN.
module rcp_iter #(
    parameter int WIDTH = 16,
    parameter int ITERS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     a_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH+1:0]     mant_o,
    output logic [$clog2(WIDTH)-1:0] shift_o,
    output logic                 div_zero_o
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam int EW = WIDTH + 2;
    localparam int PW = 2 * WIDTH + 2;
    localparam int XW = 3 * WIDTH + 4;

    localparam logic [PW-1:0] TWO_2W1 = PW'(1) << (2 * WIDTH + 1);
    localparam logic [EW-1:0] THREE_W = {2'b11, {WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] an_q, an_d;
    logic [EW-1:0]   e_q, e_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic            dz_q, dz_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [SW-1:0]    lzc_s;
    logic [WIDTH-1:0] an_norm;
    logic [EW-1:0]    seed;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    d_val;
    logic [XW-1:0]    ed;
    logic [EW-1:0]    step_e;

    function automatic logic [SW-1:0] lzc(input logic [WIDTH-1:0] v);
        logic [SW-1:0] n;
        logic          found;
        n     = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + SW'(1);
            end
        end
        return n;
    endfunction

    assign lzc_s   = lzc(an_q);
    assign an_norm = an_q << lzc_s;
    // Seed 3 - 2*an in Q2.WIDTH; an_norm has an implied binary point above its MSB.
    assign seed    = THREE_W - {1'b0, an_norm, 1'b0};

    // P and D carry 2*WIDTH fraction bits, so E*D is rescaled by 2*WIDTH back to Q2.WIDTH.
    assign prod   = PW'(an_q) * PW'(e_q);
    assign d_val  = (prod > TWO_2W1) ? '0 : (TWO_2W1 - prod);
    assign ed     = XW'(e_q) * XW'(d_val);
    assign step_e = EW'(ed >> (2 * WIDTH));

`ifdef RCP_ITER_ROUND_EN
    localparam int FW = 2 * WIDTH + 3;
    localparam logic [FW-1:0] TWO_2W = FW'(1) << (2 * WIDTH);

    logic [1:0]    fix_q, fix_d;
    logic [FW-1:0] fix_prod;
    logic          fix_ok;

    assign fix_prod = FW'(an_q) * (FW'(e_q) + FW'(1));
    assign fix_ok   = (fix_prod <= TWO_2W);
`endif

    always_comb begin
        state_d = state_q;
        an_d    = an_q;
        e_d     = e_q;
        shift_d = shift_q;
        dz_d    = dz_q;
        cnt_d   = cnt_q;
`ifdef RCP_ITER_ROUND_EN
        fix_d   = fix_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    an_d    = a_i;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                cnt_d = '0;
`ifdef RCP_ITER_ROUND_EN
                fix_d = '0;
`endif
                if (an_q == '0) begin
                    dz_d    = 1'b1;
                    e_d     = '1;
                    shift_d = '0;
                    state_d = S_DONE;
                end else begin
                    dz_d    = 1'b0;
                    shift_d = lzc_s;
                    an_d    = an_norm;
                    e_d     = seed;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                e_d   = step_e;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITERS - 1)) begin
`ifdef RCP_ITER_ROUND_EN
                    state_d = S_FIX;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef RCP_ITER_ROUND_EN
            S_FIX: begin
                // Truncated NR stays below the true quotient, so only upward steps are needed.
                if (fix_ok) begin
                    e_d   = e_q + EW'(1);
                    fix_d = fix_q + 2'd1;
                    if (fix_q == 2'd2) state_d = S_DONE;
                end else begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            an_q    <= '0;
            e_q     <= '0;
            shift_q <= '0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef RCP_ITER_ROUND_EN
            fix_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            an_q    <= an_d;
            e_q     <= e_d;
            shift_q <= shift_d;
            dz_q    <= dz_d;
            cnt_q   <= cnt_d;
`ifdef RCP_ITER_ROUND_EN
            fix_q   <= fix_d;
`endif
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign mant_o      = e_q;
    assign shift_o     = shift_q;
    assign div_zero_o  = dz_q;

endmodule

// File: tb/tb_rcp_iter.sv
// Directed and random checks of rcp_iter against a division-based reciprocal model.
module tb_rcp_iter;
    localparam int W  = 16;
    localparam int IT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_in;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] mant;
    logic [3:0]  shift;
    logic        dz;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rcp_iter #(.WIDTH(W), .ITERS(IT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .mant_o      (mant),
        .shift_o     (shift),
        .div_zero_o  (dz)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic ref_model(input logic [15:0] a, output logic [17:0] m, output logic [3:0] s);
        logic [63:0] an;
        s = 4'd0;
        if (a == 16'd0) begin
            m = 18'h3FFFF;
        end else begin
            an = 64'(a);
            while (an[15] == 1'b0) begin
                an = an << 1;
                s  = s + 4'd1;
            end
            m = 18'((64'd1 << 32) / an);
        end
    endtask

    task automatic mant_chk(input string tag, input logic [17:0] got, input logic [17:0] exp,
                            input logic exact);
`ifdef RCP_ITER_ROUND_EN
        chk(tag, 64'(got), 64'(exp));
`else
        if (exact) chk(tag, 64'(got), 64'(exp));
        else       chk(tag, 64'((got <= exp) && (32'(got) + 32'd3 >= 32'(exp))), 64'd1);
`endif
    endtask

    task automatic run_op(input logic [15:0] a, input int hold);
        logic [17:0] em;
        logic [3:0]  es;
        logic [17:0] m0;
        int          lat;
        int          guard;
        ref_model(a, em, es);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("pre_ready", 64'(in_ready), 64'd1);
        a_in      = a;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_in     = 16'd0;
        chk("busy_ready", 64'(in_ready), 64'd0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("valid_seen", 64'(out_valid), 64'd1);
        if (a == 16'd0) begin
            chk("lat_zero", 64'(lat), 64'd2);
        end else begin
`ifdef RCP_ITER_ROUND_EN
            chk("lat_round", 64'((lat >= IT + 3) && (lat <= IT + 5)), 64'd1);
`else
            chk("lat", 64'(lat), 64'(IT + 2));
`endif
        end
        mant_chk("mant", mant, em, (a == 16'd0) || (a == 16'd1));
        chk("shift", 64'(shift), 64'(es));
        chk("div_zero", 64'(dz), 64'(a == 16'd0));
        m0 = mant;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a_in     = 16'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_ready", 64'(in_ready), 64'd0);
            chk("hold_mant", 64'(mant), 64'(m0));
            chk("hold_shift", 64'(shift), 64'(es));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_valid", 64'(out_valid), 64'd0);
        chk("done_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
        $display("op a=0x%04h hold=%0d m=0x%05h s=%0d dz=%0b lat=%0d ref=0x%05h",
                 a, hold, m0, es, (a == 16'd0), lat, em);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a_in      = 16'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_mant", 64'(mant), 64'd0);
        chk("rst_shift", 64'(shift), 64'd0);
        chk("rst_dz", 64'(dz), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'd1, 0);
        run_op(16'd3, 0);
        run_op(16'hFFFF, 0);
        run_op(16'd0, 0);
        run_op(16'h1234, 5);
        run_op(16'h8000, 2);
        run_op(16'h0101, 1);

        // Abort an operation while it is iterating.
        a_in     = 16'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ready", 64'(in_ready), 64'd1);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_mant", 64'(mant), 64'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_quiet", 64'(out_valid), 64'd0);
        end
        run_op(16'd5, 0);

        for (int i = 0; i < 30; i++) begin
            run_op(16'($urandom_range(1, 16'hFFFF)), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
